// File: rtl/mem_dp_banked_pkg.sv
// mem_dp_banked_pkg: clear-FSM encoding, read-mode constants and bank-select width helper
package mem_dp_banked_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;
  typedef enum bit {RD_NEW = 1'b0, RD_OLD = 1'b1} rd_mode_e;
  function automatic int sel_w(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction
endpackage

// File: rtl/mem_dp_banked_bank.sv
// mem_dp_banked_bank: one true dual-port bank; outputs are registered and read the pre-write contents
module mem_dp_banked_bank #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 256,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_a_we,
  input  logic             i_a_re,
  input  logic [ROW_W-1:0] i_a_row,
  input  logic [WIDTH-1:0] i_a_din,
  output logic [WIDTH-1:0] o_a_q,
  input  logic             i_b_we,
  input  logic             i_b_re,
  input  logic [ROW_W-1:0] i_b_row,
  input  logic [WIDTH-1:0] i_b_din,
  output logic [WIDTH-1:0] o_b_q
);
  logic [WIDTH-1:0] r_mem [ROWS];
  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_row] <= i_a_din;
    if (i_b_we) r_mem[i_b_row] <= i_b_din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_a_q <= '0;
      o_b_q <= '0;
    end else begin
      if (i_a_re) o_a_q <= r_mem[i_a_row];
      if (i_b_re) o_b_q <= r_mem[i_b_row];
    end
endmodule

// File: rtl/mem_dp_banked.sv
// mem_dp_banked: low-order-interleaved true dual-port RAM with read-valid pipeline,
// cross-port collision/forwarding handling and a row-parallel clear sequencer
module mem_dp_banked
  import mem_dp_banked_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int NBANK      = 4,
  parameter int RD_LAT     = 1,
  parameter bit READ_FIRST = 1'b0,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_din,
  output logic [WIDTH-1:0]  a_dout,
  output logic              a_vld,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_din,
  output logic [WIDTH-1:0]  b_dout,
  output logic              b_vld,
  output logic              wr_coll
);
  localparam int BANK_W = $clog2(NBANK);
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int ROWS   = DEPTH / NBANK;
  localparam int SEL_W  = sel_w(NBANK);
  state_e r_state, w_state_nx;
  logic [ROW_W-1:0] r_row;
  logic [1:0] w_en, w_we, w_rd, w_wr, w_fwd, r_fwd;
  logic [1:0][ADDR_W-1:0] w_addr;
  logic [1:0][WIDTH-1:0] w_din, r_fwd_d;
  logic [1:0][SEL_W-1:0] w_bank, r_sel;
  logic [1:0][ROW_W-1:0] w_row;
  logic [1:0][NBANK-1:0][WIDTH-1:0] w_q;
  logic w_same, w_coll;
  logic [1:0] r_v [RD_LAT];
  logic r_c [RD_LAT];
  logic [1:0][WIDTH-1:0] w_d [RD_LAT];
  assign w_en   = {b_en, a_en};
  assign w_we   = {b_we, a_we};
  assign w_addr = {b_addr, a_addr};
  assign w_din  = {b_din, a_din};
  assign w_rd   = busy ? 2'b00 : w_en & ~w_we;
  assign w_wr   = busy ? 2'b00 : w_en & w_we;
  assign w_same = w_addr[0] == w_addr[1];
  assign w_coll = &w_wr & w_same;
  // a reader sees the other port's same-cycle write only in new-data mode
  assign w_fwd  = (READ_FIRST == RD_NEW && w_same) ? w_rd & {w_wr[0], w_wr[1]} : 2'b00;
  always_comb
    for (int p = 0; p < 2; p++) begin
      w_bank[p] = SEL_W'(w_addr[p] & ADDR_W'(NBANK - 1));
      w_row[p]  = ROW_W'(w_addr[p] >> BANK_W);
    end
  // port A of every bank doubles as the clear write port; port B loses a same-address write collision
  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    mem_dp_banked_bank #(.WIDTH(WIDTH), .ROWS(ROWS), .ROW_W(ROW_W)) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_a_we (busy | (w_wr[0] & (w_bank[0] == SEL_W'(g)))),
      .i_a_re (w_rd[0] & (w_bank[0] == SEL_W'(g))),
      .i_a_row(busy ? r_row : w_row[0]),
      .i_a_din(busy ? '0 : w_din[0]),
      .o_a_q  (w_q[0][g]),
      .i_b_we (w_wr[1] & ~w_coll & (w_bank[1] == SEL_W'(g))),
      .i_b_re (w_rd[1] & (w_bank[1] == SEL_W'(g))),
      .i_b_row(w_row[1]),
      .i_b_din(w_din[1]),
      .o_b_q  (w_q[1][g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_row   <= (r_state == ST_CLEAR) ? r_row + ROW_W'(1) : '0;
    end
  always_comb
    w_state_nx = (r_state == ST_IDLE) ? (clr ? ST_CLEAR : ST_IDLE)
                                      : ((r_row == ROW_W'(ROWS - 1)) ? ST_IDLE : ST_CLEAR);
  always_comb busy = r_state == ST_CLEAR;
  // bank select and forward data only move on a read, so the output mux holds between reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sel   <= '0;
      r_fwd   <= '0;
      r_fwd_d <= '0;
    end else
      for (int p = 0; p < 2; p++)
        if (w_rd[p]) begin
          r_sel[p]   <= w_bank[p];
          r_fwd[p]   <= w_fwd[p];
          r_fwd_d[p] <= w_din[1-p];
        end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int k = 0; k < RD_LAT; k++) begin
        r_v[k] <= '0;
        r_c[k] <= 1'b0;
      end
    else begin
      r_v[0] <= w_rd;
      r_c[0] <= w_coll;
      for (int k = 1; k < RD_LAT; k++) begin
        r_v[k] <= r_v[k-1];
        r_c[k] <= r_c[k-1];
      end
    end
  for (genvar s = 0; s < RD_LAT; s++) begin : g_pipe
    if (s == 0) begin : g_head
      assign w_d[0][0] = r_fwd[0] ? r_fwd_d[0] : w_q[0][r_sel[0]];
      assign w_d[0][1] = r_fwd[1] ? r_fwd_d[1] : w_q[1][r_sel[1]];
    end else begin : g_reg
      logic [1:0][WIDTH-1:0] r_d;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_d <= '0;
        else
          for (int p = 0; p < 2; p++)
            if (r_v[s-1][p]) r_d[p] <= w_d[s-1][p];
      assign w_d[s] = r_d;
    end
  end
  assign {b_vld, a_vld} = r_v[RD_LAT-1];
  assign a_dout  = w_d[RD_LAT-1][0];
  assign b_dout  = w_d[RD_LAT-1][1];
  assign wr_coll = r_c[RD_LAT-1];
endmodule
